// File: rtl/note_lane_scheduler.sv
// note_lane_scheduler
//
// Tempo-driven scheduler that shares one note-scroll position datapath
// between LANES note lanes. A divider produces one scroll tick every
// TICK_DIV cycles while running. On each tick, one requesting lane is
// picked round-robin and its position advances by POS_STEP. Positions
// wrap from POS_MAX back to 0.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-high reset
//   start      in   level: IDLE->RUN, PAUSE->RUN
//   pause      in   level: RUN->PAUSE, suppresses a coincident tick
//   stop       in   level: any state->IDLE, clears positions and arbiter
//   req        in   per-lane advance request, sampled on tick cycles only
//   pos_sel    in   lane index for the sel_pos read port
//   map_pulse  out  one-cycle advance strobe to the drawing logic
//   grant      out  one-hot granted lane, zero unless map_pulse
//   grant_lane out  index of the most recently granted lane
//   lane_pos   out  post-update position of the most recently granted lane
//   wrap       out  with map_pulse: the granted lane wrapped to 0
//   sel_pos    out  combinational read of the position of lane pos_sel
//   state      out  0 IDLE, 1 RUN, 2 PAUSE
module note_lane_scheduler #(
    parameter int LANES    = 4,
    parameter int TICK_DIV = 16,
    parameter int POS_STEP = 4,
    parameter int POS_MAX  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     pause,
    input  logic                     stop,
    input  logic [LANES-1:0]         req,
    input  logic [$clog2(LANES)-1:0] pos_sel,
    output logic                     map_pulse,
    output logic [LANES-1:0]         grant,
    output logic [$clog2(LANES)-1:0] grant_lane,
    output logic [7:0]               lane_pos,
    output logic                     wrap,
    output logic [7:0]               sel_pos,
    output logic [1:0]               state
);

    localparam int LW = $clog2(LANES);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [7:0]    STEP8     = 8'(POS_STEP);
    localparam logic [7:0]    MAX8      = 8'(POS_MAX);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Round-robin pick: search starts one past the last winner.
    // Returns {found, index}.
    function automatic logic [LW:0] rr_pick(input logic [LANES-1:0] r,
                                            input logic [LW-1:0]    last);
        logic          found;
        logic [LW-1:0] w;
        int            k;
        found = 1'b0;
        w     = '0;
        for (int i = 1; i <= LANES; i++) begin
            k = (int'(last) + i) % LANES;
            if (!found && r[k]) begin
                found = 1'b1;
                w     = LW'(k);
            end
        end
        return {found, w};
    endfunction

    // Position advance with wrap. Returns {wrapped, new_pos}.
    function automatic logic [8:0] pos_advance(input logic [7:0] p);
        if (p == MAX8) begin
            return {1'b1, 8'd0};
        end
        return {1'b0, p + STEP8};
    endfunction

    state_t          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [LW-1:0]   last_q, last_d;
    logic [7:0]      pos_q [LANES];
    logic [7:0]      pos_d [LANES];

    logic            map_pulse_q, map_pulse_d;
    logic [LANES-1:0] grant_q, grant_d;
    logic [LW-1:0]   grant_lane_q, grant_lane_d;
    logic [7:0]      lane_pos_q, lane_pos_d;
    logic            wrap_q, wrap_d;

    logic            tick;
    logic            fire;
    logic [LW:0]     pick;
    logic            win_found;
    logic [LW-1:0]   win_idx;
    logic [7:0]      win_pos;
    logic [8:0]      adv;

    // Tick qualification and arbitration
    always_comb begin
        tick      = (state_q == ST_RUN) && (div_q == DIV_LAST) && !pause && !stop;
        pick      = rr_pick(req, last_q);
        win_found = pick[LW];
        win_idx   = pick[LW-1:0];
        fire      = tick && win_found;
        win_pos   = 8'd0;
        for (int i = 0; i < LANES; i++) begin
            if (win_idx == LW'(i)) begin
                win_pos = pos_q[i];
            end
        end
        adv = pos_advance(win_pos);
    end

    // FSM next state and divider
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                div_d = '0;
                if (!stop && !pause && start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (pause) begin
                    // Hold the divider so a suppressed tick is retried
                    // on the first RUN cycle after resume.
                    state_d = ST_PAUSE;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (start && !pause) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // Position registers, arbiter history and registered outputs
    always_comb begin
        last_d       = last_q;
        map_pulse_d  = fire;
        grant_d      = '0;
        grant_lane_d = grant_lane_q;
        lane_pos_d   = lane_pos_q;
        wrap_d       = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            pos_d[i] = pos_q[i];
        end

        if (stop) begin
            last_d = LANE_LAST;
            for (int i = 0; i < LANES; i++) begin
                pos_d[i] = 8'd0;
            end
        end else if (fire) begin
            last_d       = win_idx;
            grant_lane_d = win_idx;
            lane_pos_d   = adv[7:0];
            wrap_d       = adv[8];
            for (int i = 0; i < LANES; i++) begin
                if (win_idx == LW'(i)) begin
                    pos_d[i]   = adv[7:0];
                    grant_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_q        <= '0;
            last_q       <= LANE_LAST;
            map_pulse_q  <= 1'b0;
            grant_q      <= '0;
            grant_lane_q <= '0;
            lane_pos_q   <= 8'd0;
            wrap_q       <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                pos_q[i] <= 8'd0;
            end
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            last_q       <= last_d;
            map_pulse_q  <= map_pulse_d;
            grant_q      <= grant_d;
            grant_lane_q <= grant_lane_d;
            lane_pos_q   <= lane_pos_d;
            wrap_q       <= wrap_d;
            for (int i = 0; i < LANES; i++) begin
                pos_q[i] <= pos_d[i];
            end
        end
    end

    // Read port; out-of-range selects read as 0
    always_comb begin
        sel_pos = 8'd0;
        for (int i = 0; i < LANES; i++) begin
            if (pos_sel == LW'(i)) begin
                sel_pos = pos_q[i];
            end
        end
    end

    assign map_pulse  = map_pulse_q;
    assign grant      = grant_q;
    assign grant_lane = grant_lane_q;
    assign lane_pos   = lane_pos_q;
    assign wrap       = wrap_q;
    assign state      = state_q;

endmodule

// File: doc/note_lane_scheduler.md
# note_lane_scheduler

Tempo-driven scheduler that shares the note-scroll position datapath between several note lanes. A tempo divider produces scroll ticks. On each tick, one requesting lane is chosen round-robin and its scroll position is advanced in steps of 4 over 0, 4, 8, 12, 16, wrapping back to 0. It sits between the lane/song logic, which raises requests, and the drawing logic, which consumes the one-cycle advance pulse, the lane id and the new position.

## Interface
- LANES, default 4: number of requesting note lanes, 2..8.
- TICK_DIV, default 16: clock cycles per scroll tick, ≥2. The divider counter width is clog2(TICK_DIV).
- POS_STEP, default 4: position increment per granted tick.
- POS_MAX, default 16: last position before wrap; must be a multiple of POS_STEP.

Ports (clock and reset first):
- clk  in  1  single system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level; moves IDLE→RUN or PAUSE→RUN.
- pause  in  1  level; moves RUN→PAUSE.
- stop  in  1  level; returns from any state to IDLE and clears all positions.
- req  in  LANES  per-lane request to advance; sampled only on tick cycles.
- pos_sel  in  clog2(LANES)  lane index for the position read port.
- map_pulse  out  1  registered; one-cycle pulse, the advance strobe to drawing.
- grant  out  LANES  registered one-hot grant; valid only with map_pulse, otherwise 0.
- grant_lane  out  clog2(LANES)  registered index of the granted lane.
- lane_pos  out  8  registered post-update position of the granted lane.
- wrap  out  1  registered; 1 with map_pulse when the granted lane wrapped from POS_MAX to 0.
- sel_pos  out  8  combinational read of the position register selected by pos_sel.
- state  out  2  current FSM state: 0 IDLE, 1 RUN, 2 PAUSE.

## Operation
- The FSM has three states: IDLE, RUN and PAUSE.
- Priority on every cycle is reset > stop > pause > start.
- IDLE:
  - Divider is held at 0 and no grants are issued.
  - start → RUN.
- RUN:
  - Divider counts 0..TICK_DIV-1 and wraps.
  - The tick cycle is divider == TICK_DIV-1.
  - pause → PAUSE; stop → IDLE.
- PAUSE:
  - Divider and all positions are frozen.
  - start with no pause → RUN; stop → IDLE.
- Tick cycle in RUN with req ≠ 0 and no pause or stop asserted:
  - Round-robin search begins at last_grant+1 modulo LANES; the first set req bit wins.
  - last_grant updates to the winner.
  - Winner position: if pos == POS_MAX, then pos ← 0 and wrap = 1; otherwise pos ← pos + POS_STEP.
  - Position arithmetic is 8-bit unsigned.
- Tick cycle with req == 0: no grant, last_grant and positions unchanged, divider wraps normally.
- Non-winning requesters are not queued. They are re-sampled at the next tick.
- pause or stop asserted on a tick cycle suppresses that tick entirely.
  - After pause, the divider stays at TICK_DIV-1, so the first RUN cycle after resume is a tick cycle.
- stop clears: divider, all positions, and last_grant to LANES-1, so lane 0 has first priority.
- Reset values:
  - state = IDLE, divider = 0, all positions = 0, last_grant = LANES-1.
  - map_pulse = 0, grant = 0, grant_lane = 0, lane_pos = 0, wrap = 0.
- Reset asserted mid-run takes effect at the next edge and discards any in-flight tick.

## Timing
- map_pulse, grant, grant_lane, lane_pos and wrap are asserted in the cycle after the tick cycle, for exactly one cycle.
- The position register update lands on the same edge, so sel_pos reflects the new value in the same cycle as map_pulse.
- Back-to-back grants are spaced exactly TICK_DIV cycles apart while in RUN.
- Entering RUN from IDLE: first tick is TICK_DIV cycles after the cycle start is sampled. The first map_pulse follows one cycle later.
- state output changes on the edge after the controlling input is sampled.
- grant is never multi-hot. map_pulse == |grant at all times.

## Test plan
- Reset, then start, then req=4'b0001 held, TICK_DIV=16 → map_pulse every 16 cycles. lane_pos sequence is 4, 8, 12, 16, 0 with wrap=1 on the 0. The first pulse arrives 17 cycles after start is sampled.
- req=4'b1111 held → grant_lane sequence 0, 1, 2, 3, 0, and every lane reads 4 then 8 via sel_pos.
- req=4'b0101 with last_grant=0 → grant lane 2, then lane 0. Lanes 1 and 3 positions stay 0.
- pause asserted exactly on a tick cycle → no map_pulse that period. After 10 cycles of PAUSE, start → map_pulse on the second cycle of RUN, and positions are unchanged during PAUSE.
- stop during RUN with lane 0 at 12 → state=IDLE next cycle, all sel_pos = 0, and after start the first grant goes to lane 0 with req=4'b1001.
- reset asserted mid-RUN on a tick cycle → no map_pulse, and all outputs are 0 and state=IDLE after the edge.
